enc_feed_ctrl: RTL
==================

# enc_feed_ctrl

Frame loader and sequencer that sits directly upstream of the batched fixed-point encoder layer. It collects IN_SIZE signed fixed-point samples from a serial valid/ready stream into a packed feature vector, holds the encoder in reset while filling, and releases it to run. It then captures the encoder result when `enc_done` rises and presents it downstream on a valid/ready port.

## Interface
- `BITSIZE`, 16, width of one fixed-point sample (two's complement)
- `IN_SIZE`, 92, samples per frame (encoder input count)
- `OUT_SIZE`, 2, encoder output count
- `TIMEOUT_CYCLES`, 64, RUN-state watchdog limit (used only with the macro)
- `clk`  in  1  single clock, all logic on rising edge
- `reset`  in  1  synchronous, active-high
- `s_data`  in  BITSIZE  incoming sample
- `s_valid`  in  1  sample valid
- `s_ready`  out  1  loader accepts sample
- `x_out`  out  BITSIZE*IN_SIZE  packed frame; sample k at `[k*BITSIZE +: BITSIZE]`, first accepted = k=0
- `enc_reset`  out  1  drives encoder `reset`
- `enc_done`  in  1  encoder `done_all`
- `enc_y`  in  BITSIZE*OUT_SIZE  encoder `y`
- `y_out`  out  BITSIZE*OUT_SIZE  captured result
- `y_valid`  out  1  result valid
- `y_ready`  in  1  downstream accepts result
- `err`  out  1  one-cycle pulse on watchdog expiry (constant 0 without macro)

## Operation
- States: FILL, RUN, HOLD.
- FILL: `s_ready`=1, `enc_reset`=1. A handshake (`s_valid & s_ready`) writes `s_data` into slot `cnt`, then `cnt`++. The handshake with `cnt`==IN_SIZE-1 moves to RUN and clears `cnt`.
- RUN: `s_ready`=0, `enc_reset`=0, `x_out` frozen. The first cycle `enc_done` is sampled high, `enc_y` is registered into `y_out`, `y_valid` is set, and the state moves to HOLD.
- HOLD: `y_out` stable, `enc_reset`=0, `y_valid`=1. When `y_valid & y_ready`, clear `y_valid` and go to FILL. `s_ready` rises on the following cycle, never in the same cycle.
- `x_out` slots are not cleared between frames; each frame overwrites every slot.
- There is no arithmetic in this block. Data passes bit-exact with no sign extension or saturation.
- `enc_done` seen in FILL or HOLD is ignored.
- `y_out` keeps its last value after the handshake until the next capture.

## Timing
- Reset values: state FILL, `cnt`=0, `s_ready`=1 on the first cycle after reset, `enc_reset`=1, `x_out`=0, `y_out`=0, `y_valid`=0, `err`=0.
- All outputs are registered or decoded from registered state. There are no combinational input-to-output paths.
- Throughput: one sample per cycle in FILL.
- `enc_reset` falls on the same edge that captures the last sample.
- With the default encoder (BATCH 32, BATCH_COUNT 3):
  - `enc_done` rises 5 edges after `enc_reset` falls.
  - `y_valid` rises 6 edges after the last sample handshake.
- Reset asserted mid-frame or mid-RUN: all state returns to reset values on that edge, the partial frame is discarded, and the next frame starts at slot 0.
- `y_valid` does not depend on `y_ready`. Downstream may hold `y_ready` low indefinitely; HOLD persists and upstream is back-pressured.

## Configuration
- `ENC_FEED_TIMEOUT_EN` defined:
  - A RUN-state counter starts at 0 on RUN entry.
  - If the counter reaches TIMEOUT_CYCLES-1 with `enc_done` still low, `err` pulses for 1 cycle and the state returns to FILL: `enc_reset`=1, frame dropped, `y_valid` stays 0.
  - If `enc_done` is sampled high on the same cycle the counter reaches TIMEOUT_CYCLES-1, the capture wins.
- Not defined: no counter is built, RUN waits forever, and `err` is tied to 0.

## Structure
- Shared package `enc_pkg` holds:
  - `BITSIZE`, `IN_SIZE`, `OUT_SIZE` defaults
  - the `enc_feed_state_t` enum (FILL, RUN, HOLD)
  - the `ENC_CNT_W` = $clog2(IN_SIZE) constant
- Sub-module `enc_feed_timer`: load/count/expire counter, instantiated only under `ENC_FEED_TIMEOUT_EN`.

## Test plan
- Continuous stream, `s_data`=k for k=0..91 -> 92 handshakes on consecutive cycles, `x_out` slot k = k, `enc_reset` low on the edge after handshake 92, `s_ready` low.
- Stub encoder raises `enc_done` 5 cycles after `enc_reset` falls with `enc_y`=32'h0012_0034; `y_ready` held low for 10 cycles -> `y_valid` high for the whole time, `y_out`=32'h0012_0034, no `s_ready`.
- `y_ready` high when `y_valid` rises -> `y_valid` high exactly 1 cycle, then FILL with `s_ready`=1 and `enc_reset`=1 on the next cycle.
- `s_valid` toggling every other cycle with values 0xA000+k -> exactly 92 captures with no skipped or duplicated slots, and RUN entered after the 92nd accepted sample.
- Reset pulsed after sample 40, then a fresh 92-sample frame of 0x7FFF -> all outputs at reset values, and the new frame fills slots 0..91 with 0x7FFF.
- Macro defined, TIMEOUT_CYCLES=16, stub never raises `enc_done` -> `err` pulses once 16 cycles after RUN entry, return to FILL, `y_valid` never set. Macro undefined -> RUN persists and `err` stays 0.

Source files
------------

// File: rtl/enc_pkg.sv
// Shared defaults and state encoding for the encoder feed controller.
package enc_pkg;

   localparam int unsigned BITSIZE   = 16;
   localparam int unsigned IN_SIZE   = 92;
   localparam int unsigned OUT_SIZE  = 2;
   localparam int unsigned ENC_CNT_W = $clog2(IN_SIZE);

   typedef enum logic [1:0] {
      FILL = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2
   } enc_feed_state_t;

endpackage

// File: rtl/enc_feed_timer.sv
// RUN-state watchdog: clears while idle, counts while running, flags the last allowed cycle.
module enc_feed_timer #(
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic clk,
   input  logic reset,
   input  logic run_i,
   output logic expire_o
);

   localparam int unsigned W = $clog2(TIMEOUT_CYCLES) + 1;

   logic [W-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (reset || !run_i) begin
         cnt_q <= '0;
      end else if (!expire_o) begin
         cnt_q <= cnt_q + W'(1);
      end
   end

   assign expire_o = run_i && (cnt_q == W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/enc_feed_ctrl.sv
// Frame loader / sequencer for the fixed-point encoder: fill, run, hold result.
// Optional RUN watchdog enabled by defining ENC_FEED_TIMEOUT_EN.
module enc_feed_ctrl
   import enc_pkg::*;
#(
   parameter int unsigned BITSIZE        = enc_pkg::BITSIZE,
   parameter int unsigned IN_SIZE        = enc_pkg::IN_SIZE,
   parameter int unsigned OUT_SIZE       = enc_pkg::OUT_SIZE,
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [BITSIZE-1:0]           s_data,
   input  logic                         s_valid,
   output logic                         s_ready,
   output logic [BITSIZE*IN_SIZE-1:0]   x_out,
   output logic                         enc_reset,
   input  logic                         enc_done,
   input  logic [BITSIZE*OUT_SIZE-1:0]  enc_y,
   output logic [BITSIZE*OUT_SIZE-1:0]  y_out,
   output logic                         y_valid,
   input  logic                         y_ready,
   output logic                         err
);

   localparam int unsigned CNT_W = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 1;
   localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(IN_SIZE - 1);

   enc_feed_state_t               state_q;
   logic [CNT_W-1:0]              cnt_q;
   logic [BITSIZE-1:0]            slot_q [IN_SIZE];
   logic [BITSIZE*OUT_SIZE-1:0]   y_q;
   logic                          err_q;
   logic                          timeout_c;

`ifdef ENC_FEED_TIMEOUT_EN
   enc_feed_timer #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timer (
      .clk      (clk),
      .reset    (reset),
      .run_i    (state_q == RUN),
      .expire_o (timeout_c)
   );
`else
   assign timeout_c = 1'b0;
`endif

   // Sequencer: a result capture in RUN takes priority over a same-cycle timeout.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= FILL;
         cnt_q   <= '0;
         y_q     <= '0;
         err_q   <= 1'b0;
         for (int i = 0; i < int'(IN_SIZE); i++) begin
            slot_q[i] <= '0;
         end
      end else begin
         err_q <= 1'b0;
         case (state_q)
            FILL: begin
               if (s_valid) begin
                  slot_q[cnt_q] <= s_data;
                  if (cnt_q == LAST_SLOT) begin
                     cnt_q   <= '0;
                     state_q <= RUN;
                  end else begin
                     cnt_q <= cnt_q + CNT_W'(1);
                  end
               end
            end
            RUN: begin
               if (enc_done) begin
                  y_q     <= enc_y;
                  state_q <= HOLD;
               end else if (timeout_c) begin
                  err_q   <= 1'b1;
                  state_q <= FILL;
               end
            end
            HOLD: begin
               if (y_ready) begin
                  state_q <= FILL;
               end
            end
            default: state_q <= FILL;
         endcase
      end
   end

   for (genvar k = 0; k < int'(IN_SIZE); k++) begin : g_pack
      assign x_out[k*BITSIZE +: BITSIZE] = slot_q[k];
   end

   assign s_ready   = (state_q == FILL);
   assign enc_reset = (state_q == FILL);
   assign y_valid   = (state_q == HOLD);
   assign y_out     = y_q;
   assign err       = err_q;

endmodule
